multibank_capture_controller: RTL and testbench

Parametrised write-side controller for the spectrogram capture RAM. The RAM is split into NUM_BANKS banks of DEPTH words each. On detection events, the block fills banks round-robin and reports each closed bank with its length. It waits for the readout side to release a bank before reusing it. It replaces the fixed two-bank scheme and adds explicit bank release, chained capture across banks and overflow reporting.

---
 rtl/capture_pkg.sv | 11 +
 rtl/bank_status_tracker.sv | 52 +++++
 rtl/multibank_capture_controller.sv | 191 +++++++++++++++++++
 tb/tb_multibank_capture_controller.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared definitions for the multibank capture controller: FSM state encodings.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CLOSE   = 2'd2,
    STALL   = 2'd3
  } state_t;

endpackage

// File: rtl/bank_status_tracker.sv
// Bank occupancy bitmap: a bank is set when closed and cleared when released.
// A set on the same edge as a release of the same bank wins.
module bank_status_tracker #(
  parameter  int NUM_BANKS = 2,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_valid,
  input  logic [BANK_W-1:0]    set_bank,
  input  logic                 release_valid,
  input  logic [BANK_W-1:0]    release_bank,
  input  logic [BANK_W-1:0]    query_bank,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 query_full
);

  localparam logic [NUM_BANKS-1:0] BIT0 = {{(NUM_BANKS-1){1'b0}}, 1'b1};

  logic [NUM_BANKS-1:0] bank_full_r;
  logic [NUM_BANKS-1:0] set_mask_s;
  logic [NUM_BANKS-1:0] rel_mask_s;

  // One-hot masks for the bank being closed and the bank being released.
  always_comb begin
    set_mask_s = {NUM_BANKS{1'b0}};
    rel_mask_s = {NUM_BANKS{1'b0}};
    if (set_valid) begin
      set_mask_s = BIT0 << set_bank;
    end else begin
      set_mask_s = {NUM_BANKS{1'b0}};
    end
    if (release_valid) begin
      rel_mask_s = BIT0 << release_bank;
    end else begin
      rel_mask_s = {NUM_BANKS{1'b0}};
    end
  end

  // Occupancy register; OR-ing the set mask last gives set-wins priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full_r <= {NUM_BANKS{1'b0}};
    end else begin
      bank_full_r <= (bank_full_r & ~rel_mask_s) | set_mask_s;
    end
  end

  assign bank_full  = bank_full_r;
  assign query_full = bank_full_r[query_bank];

endmodule

// File: rtl/multibank_capture_controller.sv
// Round-robin write-side controller for the banked spectrogram capture RAM.
// Optional capture/drop statistics counters are built when CAPTURE_STATS_EN is defined.
module multibank_capture_controller
  import capture_pkg::*;
#(
  parameter  int NUM_BANKS = 2,
  parameter  int DEPTH     = 200,
  localparam int BANK_W    = $clog2(NUM_BANKS),
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    signal_detected,
  input  logic                    release_valid,
  input  logic [BANK_W-1:0]       release_bank,
  output logic                    we,
  output logic [BANK_W+IDX_W-1:0] addr,
  output logic [BANK_W-1:0]       cur_bank,
  output logic [NUM_BANKS-1:0]    bank_full,
  output logic                    done_valid,
  output logic [BANK_W-1:0]       done_bank,
  output logic [LEN_W-1:0]        done_len,
  output logic                    overflow,
  output logic [1:0]              state,
  output logic [15:0]             capture_count,
  output logic [15:0]             drop_count
);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [BANK_W-1:0] BANK_ONE = BANK_W'(1);
  localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(DEPTH);

  state_t            state_r, state_n;
  logic [IDX_W-1:0]  idx_r, idx_n;
  logic [LEN_W-1:0]  len_r, len_n;
  logic [BANK_W-1:0] cur_bank_r, cur_bank_n;
  logic              done_valid_r, done_valid_n;
  logic [BANK_W-1:0] done_bank_r, done_bank_n;
  logic [LEN_W-1:0]  done_len_r, done_len_n;
  logic              overflow_r, overflow_n;
  logic              we_s;
  logic              set_valid_s;
  logic [BANK_W-1:0] query_bank_s;
  logic              query_full_s;

  // In CLOSE the lookup targets the bank after the pending advance.
  assign query_bank_s = (state_r == CLOSE && len_r != {LEN_W{1'b0}}) ?
                        cur_bank_r + BANK_ONE : cur_bank_r;

  bank_status_tracker #(.NUM_BANKS(NUM_BANKS)) u_tracker (
    .clk          (clk),
    .reset        (reset),
    .set_valid    (set_valid_s),
    .set_bank     (cur_bank_r),
    .release_valid(release_valid),
    .release_bank (release_bank),
    .query_bank   (query_bank_s),
    .bank_full    (bank_full),
    .query_full   (query_full_s)
  );

  // Next-state, index, length and report logic.
  always_comb begin
    state_n      = state_r;
    idx_n        = idx_r;
    len_n        = len_r;
    cur_bank_n   = cur_bank_r;
    done_valid_n = 1'b0;
    done_bank_n  = done_bank_r;
    done_len_n   = done_len_r;
    overflow_n   = 1'b0;
    set_valid_s  = 1'b0;
    we_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (signal_detected && !query_full_s) begin
          state_n = CAPTURE;
          idx_n   = {IDX_W{1'b0}};
        end else if (signal_detected) begin
          state_n    = STALL;
          overflow_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      CAPTURE: begin
        we_s = signal_detected;
        if (!signal_detected) begin
          len_n   = LEN_W'(idx_r);
          state_n = CLOSE;
        end else if (idx_r == IDX_LAST) begin
          len_n   = LEN_FULL;
          state_n = CLOSE;
        end else begin
          idx_n = idx_r + IDX_ONE;
        end
      end
      CLOSE: begin
        idx_n = {IDX_W{1'b0}};
        if (len_r != {LEN_W{1'b0}}) begin
          done_valid_n = 1'b1;
          done_bank_n  = cur_bank_r;
          done_len_n   = len_r;
          set_valid_s  = 1'b1;
          cur_bank_n   = cur_bank_r + BANK_ONE;
        end else begin
          cur_bank_n = cur_bank_r;
        end
        if (signal_detected && !query_full_s) begin
          state_n = CAPTURE;
        end else if (signal_detected) begin
          state_n    = STALL;
          overflow_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      STALL: begin
        if (!signal_detected) begin
          state_n = IDLE;
        end else begin
          state_n = STALL;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered report outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      idx_r        <= {IDX_W{1'b0}};
      len_r        <= {LEN_W{1'b0}};
      cur_bank_r   <= {BANK_W{1'b0}};
      done_valid_r <= 1'b0;
      done_bank_r  <= {BANK_W{1'b0}};
      done_len_r   <= {LEN_W{1'b0}};
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_n;
      idx_r        <= idx_n;
      len_r        <= len_n;
      cur_bank_r   <= cur_bank_n;
      done_valid_r <= done_valid_n;
      done_bank_r  <= done_bank_n;
      done_len_r   <= done_len_n;
      overflow_r   <= overflow_n;
    end
  end

`ifdef CAPTURE_STATS_EN
  logic [15:0] capture_count_r;
  logic [15:0] drop_count_r;

  // Saturating counts of reported banks and dropped detections.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_count_r <= 16'h0000;
      drop_count_r    <= 16'h0000;
    end else begin
      if (done_valid_r && capture_count_r != 16'hFFFF) begin
        capture_count_r <= capture_count_r + 16'h0001;
      end
      if (overflow_r && drop_count_r != 16'hFFFF) begin
        drop_count_r <= drop_count_r + 16'h0001;
      end
    end
  end

  assign capture_count = capture_count_r;
  assign drop_count    = drop_count_r;
`else
  assign capture_count = 16'h0000;
  assign drop_count    = 16'h0000;
`endif

  assign we         = we_s;
  assign addr       = {cur_bank_r, idx_r};
  assign cur_bank   = cur_bank_r;
  assign done_valid = done_valid_r;
  assign done_bank  = done_bank_r;
  assign done_len   = done_len_r;
  assign overflow   = overflow_r;
  assign state      = state_r;

endmodule

// File: tb/tb_multibank_capture_controller.sv
// Directed bench for multibank_capture_controller with NUM_BANKS=2, DEPTH=8.
module tb_multibank_capture_controller;

  logic        clk;
  logic        reset;
  logic        signal_detected;
  logic        release_valid;
  logic [0:0]  release_bank;
  logic        we;
  logic [3:0]  addr;
  logic [0:0]  cur_bank;
  logic [1:0]  bank_full;
  logic        done_valid;
  logic [0:0]  done_bank;
  logic [3:0]  done_len;
  logic        overflow;
  logic [1:0]  state;
  logic [15:0] capture_count;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [3:0] wr_q[$];
  logic [0:0] db_q[$];
  logic [3:0] dl_q[$];
  int         ovf_n;
  int         stall_we_n;

  multibank_capture_controller #(.NUM_BANKS(2), .DEPTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .signal_detected(signal_detected),
    .release_valid  (release_valid),
    .release_bank   (release_bank),
    .we             (we),
    .addr           (addr),
    .cur_bank       (cur_bank),
    .bank_full      (bank_full),
    .done_valid     (done_valid),
    .done_bank      (done_bank),
    .done_len       (done_len),
    .overflow       (overflow),
    .state          (state),
    .capture_count  (capture_count),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_log();
    wr_q.delete();
    db_q.delete();
    dl_q.delete();
    ovf_n      = 0;
    stall_we_n = 0;
  endtask

  task automatic do_reset();
    signal_detected = 1'b0;
    release_valid   = 1'b0;
    release_bank    = 1'b0;
    reset           = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
  endtask

  // Drives ncyc cycles of sd, optionally pulsing a release on cycle rel_at, and logs activity.
  task automatic drive(input int ncyc, input int rel_at, input logic [0:0] rbank, input logic sd);
    for (int i = 0; i < ncyc; i++) begin
      signal_detected = sd;
      release_valid   = (i == rel_at);
      release_bank    = rbank;
      #1;
      if (we) wr_q.push_back(addr);
      if (state == 2'd3 && we) stall_we_n++;
      @(posedge clk);
      #1;
      if (done_valid) begin
        db_q.push_back(done_bank);
        dl_q.push_back(done_len);
      end
      if (overflow) ovf_n++;
    end
    release_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    signal_detected = 1'b0;
    release_valid = 1'b0;
    release_bank = 1'b0;
    #2;
    checks++;
    if ({state, cur_bank, bank_full, done_valid, done_bank, done_len, overflow, addr, we} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got state=%0d cur=%0d full=%b dv=%b db=%0d dl=%0d ovf=%b addr=%0d we=%b, need all 0",
               state, cur_bank, bank_full, done_valid, done_bank, done_len, overflow, addr, we);
    end
    checks++;
    if (capture_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d need 0/0", capture_count, drop_count);
    end
    do_reset();
  endtask

  task automatic test_single_capture();
    do_reset();
    drive(6, -1, 1'b0, 1'b1);
    drive(3, -1, 1'b0, 1'b0);
    checks++;
    if (wr_q.size() != 5) begin
      errors++;
      $display("FAIL single_writes: got %0d writes need 5", wr_q.size());
    end
    for (int k = 0; k < wr_q.size() && k < 5; k++) begin
      checks++;
      if (wr_q[k] !== 4'(k)) begin
        errors++;
        $display("FAIL single_addr[%0d]: got %0d need %0d", k, wr_q[k], k);
      end
    end
    checks++;
    if (db_q.size() != 1 || db_q[0] !== 1'b0 || dl_q[0] !== 4'd5) begin
      errors++;
      $display("FAIL single_done: got n=%0d need one report bank 0 len 5", db_q.size());
    end
    checks++;
    if (bank_full !== 2'b01 || cur_bank !== 1'b1 || state !== 2'd0) begin
      errors++;
      $display("FAIL single_after: got full=%b cur=%0d state=%0d need 01/1/0", bank_full, cur_bank, state);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(24, -1, 1'b0, 1'b1);
    checks++;
    if (wr_q.size() != 16) begin
      errors++;
      $display("FAIL ovf_writes: got %0d need 16", wr_q.size());
    end
    for (int k = 0; k < wr_q.size() && k < 16; k++) begin
      checks++;
      if (wr_q[k] !== 4'(k)) begin
        errors++;
        $display("FAIL ovf_addr[%0d]: got %0d need %0d", k, wr_q[k], k);
      end
    end
    checks++;
    if (db_q.size() != 2 || db_q[0] !== 1'b0 || dl_q[0] !== 4'd8 || db_q[1] !== 1'b1 || dl_q[1] !== 4'd8) begin
      errors++;
      $display("FAIL ovf_done: got %0d reports need (0,8),(1,8)", db_q.size());
    end
    checks++;
    if (ovf_n != 1) begin
      errors++;
      $display("FAIL ovf_pulses: got %0d need 1", ovf_n);
    end
    checks++;
    if (stall_we_n != 0 || state !== 2'd3) begin
      errors++;
      $display("FAIL ovf_stall: got stall writes=%0d state=%0d need 0/3", stall_we_n, state);
    end
    drive(1, -1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd0 || bank_full !== 2'b11 || cur_bank !== 1'b0) begin
      errors++;
      $display("FAIL ovf_exit: got state=%0d full=%b cur=%0d need 0/11/0", state, bank_full, cur_bank);
    end
  endtask

  task automatic test_chained_release();
    do_reset();
    drive(26, 12, 1'b0, 1'b1);
    drive(3, -1, 1'b0, 1'b0);
    checks++;
    if (wr_q.size() != 23) begin
      errors++;
      $display("FAIL chain_writes: got %0d need 23", wr_q.size());
    end
    for (int k = 0; k < wr_q.size() && k < 23; k++) begin
      checks++;
      if (wr_q[k] !== 4'(k % 16)) begin
        errors++;
        $display("FAIL chain_addr[%0d]: got %0d need %0d", k, wr_q[k], k % 16);
      end
    end
    checks++;
    if (db_q.size() != 3 || dl_q[0] !== 4'd8 || dl_q[1] !== 4'd8 || db_q[2] !== 1'b0 || dl_q[2] !== 4'd7) begin
      errors++;
      $display("FAIL chain_done: got %0d reports need (0,8),(1,8),(0,7)", db_q.size());
    end
    checks++;
    if (ovf_n != 0 || bank_full !== 2'b11 || cur_bank !== 1'b1) begin
      errors++;
      $display("FAIL chain_after: got ovf=%0d full=%b cur=%0d need 0/11/1", ovf_n, bank_full, cur_bank);
    end
  endtask

  task automatic test_one_cycle();
    do_reset();
    drive(1, -1, 1'b0, 1'b1);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL one_enter: got state=%0d need 1", state);
    end
    drive(1, -1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd2 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL one_close: got state=%0d writes=%0d need 2/0", state, wr_q.size());
    end
    drive(2, -1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd0 || db_q.size() != 0 || cur_bank !== 1'b0 || bank_full !== 2'b00) begin
      errors++;
      $display("FAIL one_after: got state=%0d reports=%0d cur=%0d full=%b need 0/0/0/00",
               state, db_q.size(), cur_bank, bank_full);
    end
  endtask

  task automatic test_set_wins_and_reset();
    do_reset();
    drive(3, -1, 1'b0, 1'b1);
    drive(1, -1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL setwin_close: got state=%0d need 2", state);
    end
    drive(1, 0, 1'b0, 1'b0);
    checks++;
    if (bank_full !== 2'b01 || db_q.size() != 1 || dl_q[0] !== 4'd2) begin
      errors++;
      $display("FAIL setwin_full: got full=%b reports=%0d need 01 and one len 2", bank_full, db_q.size());
    end
    drive(1, 0, 1'b1, 1'b0);
    checks++;
    if (bank_full !== 2'b01) begin
      errors++;
      $display("FAIL release_empty: got full=%b need 01", bank_full);
    end
    drive(4, -1, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || addr !== 4'd0 || cur_bank !== 1'b0 || bank_full !== 2'b00 ||
        done_bank !== 1'b0 || done_len !== 4'd0) begin
      errors++;
      $display("FAIL midreset: got state=%0d addr=%0d cur=%0d full=%b db=%0d dl=%0d need all 0",
               state, addr, cur_bank, bank_full, done_bank, done_len);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
    drive(3, -1, 1'b0, 1'b0);
    checks++;
    if (db_q.size() != 0 || state !== 2'd0) begin
      errors++;
      $display("FAIL midreset_nodone: got reports=%0d state=%0d need 0/0", db_q.size(), state);
    end
  endtask

  task automatic test_stats();
    do_reset();
    drive(3, -1, 1'b0, 1'b1);
    drive(3, -1, 1'b0, 1'b0);
    drive(1, 0, 1'b0, 1'b0);
    drive(3, -1, 1'b0, 1'b1);
    drive(3, -1, 1'b0, 1'b0);
    drive(3, -1, 1'b0, 1'b1);
    drive(3, -1, 1'b0, 1'b0);
    drive(2, -1, 1'b0, 1'b1);
    drive(2, -1, 1'b0, 1'b0);
    drive(2, -1, 1'b0, 1'b1);
    drive(2, -1, 1'b0, 1'b0);
    checks++;
    if (db_q.size() != 3 || ovf_n != 2) begin
      errors++;
      $display("FAIL stats_events: got reports=%0d drops=%0d need 3/2", db_q.size(), ovf_n);
    end
`ifdef CAPTURE_STATS_EN
    checks++;
    if (capture_count !== 16'd3 || drop_count !== 16'd2) begin
      errors++;
      $display("FAIL stats_counts: got %0d/%0d need 3/2", capture_count, drop_count);
    end
`else
    checks++;
    if (capture_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_counts: got %0d/%0d need 0/0", capture_count, drop_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_overflow();
    test_chained_release();
    test_one_cycle();
    test_set_wins_and_reset();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
